bit_packer: RTL and testbench
=============================

Name: bit_packer

Overview:
- Write-side counterpart of the 32-bit word to variable-length bit-field extractor.
- Accepts fields of 1-15 bits per cycle and packs them MSB-first into 32-bit words.
- Emits each word with a one-cycle push strobe. No backpressure.
- An explicit flush zero-pads the partial word and emits it, closing a stream so that the extractor on the far side sees word-aligned data.

Parameters:
- WORD_W, 32, output word width.
- FIELD_W, 15, maximum field width, which is also the datain width.
- LEN_W, 4, width of the length field.
- CNT_W, 6, width of the residual bit counter (must hold 0..WORD_W-1+FIELD_W).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- pushin  input  1  field valid this cycle.
- lenin  input  LEN_W  field length in bits, 0..15. A value of 0 is a no-op.
- datain  input  FIELD_W  field value, right-justified in the low lenin bits. Bits above lenin are ignored and masked internally.
- flushin  input  1  pad and emit the partial word after this cycle's field (if any).
- pushout  output  1  dataout valid, single-cycle strobe.
- dataout  output  WORD_W  packed word; the first field bit is in bit 31.
- fillout  output  CNT_W  residual bits held after this cycle's update, 0..31.

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous and active-high.
  - Reset clears pushout=0, dataout=0, fillout=0, the accumulator, and the flush-pending flag.
  - Reset mid-stream discards the residual bits silently; no word is emitted.
- Accumulator:
  - Width is WORD_W+FIELD_W = 47 bits, MSB-aligned, with residual count cnt.
  - A push with lenin=L appends the masked field immediately below the existing cnt bits; cnt += L.
- Word completion:
  - If cnt+L >= 32, the top 32 bits form a word, which is registered to dataout with pushout=1 on the next edge (latency 1 cycle).
  - The accumulator then shifts left by 32 and cnt becomes cnt+L-32 (at most 14).
  - At most one word completes per push, because L <= 15 < 32.
- Output holding: dataout holds its last value when pushout=0. The bench checks dataout only when pushout=1.
- State machine has two states:
  - RUN: normal accumulation.
  - FLUSH_PEND: entered when a flush leaves residual bits that cannot be emitted this cycle.
- Flush handling (flushin=1 in RUN), evaluated after this cycle's push:
  - Post-push cnt==0 and no word completed: nothing happens; stay in RUN.
  - No word completed and 0 < cnt < 32: emit the residual, zero-padded in the low bits, as this cycle's word; cnt becomes 0; stay in RUN.
  - A word completed and residual r>0: emit the completed word now; go to FLUSH_PEND holding r bits.
  - A word completed and residual r==0: emit the word only; stay in RUN.
- FLUSH_PEND (always exactly one cycle, then RUN):
  - Emit the held residual, zero-padded (pushout=1).
  - Any push this cycle starts a fresh accumulator at cnt=0. That push cannot complete a word because L <= 15.
  - A flushin this cycle applies to the fresh accumulator after the pending word. If the fresh cnt>0, the FSM re-enters FLUSH_PEND, so consecutive pushout pulses result.
- No-op inputs: pushin=0 with lenin ignored, and pushin=1 with lenin=0, leave state unchanged.
- fillout: a registered copy of cnt after each update. In FLUSH_PEND it shows the fresh cnt.
- Arithmetic: all length arithmetic is unsigned in CNT_W bits; no overflow is possible within the stated ranges.

Decomposition:
- Package bit_packer_pkg holds:
  - WORD_W, FIELD_W, LEN_W, CNT_W.
  - The state enum {RUN, FLUSH_PEND}.
  - A field-mask function (lenin -> FIELD_W-bit mask).
- One natural sub-module, bit_packer_acc, contains:
  - the 47-bit accumulator and cnt;
  - the append, shift and word-extract logic.
- The top level holds the FSM and the output registers.

Test Plan:
- Reset: assert reset for 2 cycles mid-stream with fillout=20 -> pushout=0, dataout=0, fillout=0; no word emitted afterwards from the old data.
- Pack 8 pushes of len 4 with data 1,2,...,8 -> one cycle after the 8th push: pushout=1, dataout=0x12345678, fillout=0.
- Push len15 0x7FFF, len15 0x0000, len4 0xF -> pushout=1, dataout=0xFFFE0003, fillout=2.
- Flush residual: continue the previous scenario with flushin=1 and pushin=0 -> next cycle pushout=1, dataout=0xC0000000, fillout=0.
- Flush straddling a word: 7 pushes len4 with data 1..7 (fill 28), then len12 0xABC with flushin=1 -> two consecutive words, dataout=0x1234567A then 0xBC000000; fillout goes 8 then 0.
- Masking and no-op: push len3 datain=0x7FFF, then len0 0x1234, then flushin -> single word 0xE0000000; the len0 push changes nothing.

Source files
------------

// File: rtl/bit_packer_pkg.sv
// Shared widths, FSM state type and field-mask helper for the MSB-first bit packer.
// Fields of 1..FIELD_W bits are packed into WORD_W-bit words.
package bit_packer_pkg;

  localparam int WORD_W  = 32;
  localparam int FIELD_W = 15;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 6;
  localparam int ACC_W   = WORD_W + FIELD_W;

  typedef enum logic [0:0] {
    RUN        = 1'b0,
    FLUSH_PEND = 1'b1
  } state_e;

  // Ones in the low len bits; len==0 yields an all-zero mask.
  function automatic logic [FIELD_W-1:0] field_mask(input logic [LEN_W-1:0] len);
    logic [FIELD_W:0] full;
    full = ((FIELD_W+1)'(1) << len) - (FIELD_W+1)'(1);
    return full[FIELD_W-1:0];
  endfunction

endpackage

// File: rtl/bit_packer_acc.sv
// MSB-aligned bit accumulator: appends a masked field below the held bits and
// peels off a full word when one completes.
module bit_packer_acc
  import bit_packer_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [FIELD_W-1:0] data_i,
  input  logic              fresh_i,
  input  logic              drop_i,
  output logic [WORD_W-1:0] held_word_o,
  output logic [WORD_W-1:0] word_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  post_cnt_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   base;
  logic [ACC_W-1:0]   merged;
  logic [ACC_W-1:0]   post_acc;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   base_cnt;
  logic [CNT_W-1:0]   sum;
  logic [LEN_W-1:0]   len_eff;
  logic [FIELD_W-1:0] field_lj;

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    len_eff    = push_i ? len_i : '0;
    // Left-justify the field so a single right shift by the fill drops it into place.
    field_lj   = (data_i & field_mask(len_eff)) << (LEN_W'(FIELD_W) - len_eff);
    base       = fresh_i ? '0 : acc_q;
    base_cnt   = fresh_i ? '0 : cnt_q;
    merged     = base | ({field_lj, {WORD_W{1'b0}}} >> base_cnt);
    sum        = base_cnt + CNT_W'(len_eff);
    done_o     = (sum >= CNT_W'(WORD_W));
    post_acc   = done_o ? (merged << WORD_W) : merged;
    post_cnt_o = done_o ? (sum - CNT_W'(WORD_W)) : sum;
  end

  assign word_o      = merged[ACC_W-1 -: WORD_W];
  assign held_word_o = acc_q[ACC_W-1 -: WORD_W];
  assign cnt_o       = cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || drop_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= post_acc;
      cnt_q <= post_cnt_o;
    end
  end

endmodule

// File: rtl/bit_packer.sv
// Packs 1..15-bit fields MSB-first into 32-bit words with a one-cycle push strobe;
// flushin zero-pads and emits the partial word, possibly over two cycles.
module bit_packer
  import bit_packer_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               pushin,
  input  logic [LEN_W-1:0]   lenin,
  input  logic [FIELD_W-1:0] datain,
  input  logic               flushin,
  output logic               pushout,
  output logic [WORD_W-1:0]  dataout,
  output logic [CNT_W-1:0]   fillout
);

  state_e              state_q;
  state_e              state_d;
  logic                pushout_q;
  logic                pushout_d;
  logic [WORD_W-1:0]   dataout_q;
  logic [WORD_W-1:0]   dataout_d;
  logic                fresh;
  logic                drop;
  logic                done;
  logic [WORD_W-1:0]   word;
  logic [WORD_W-1:0]   held_word;
  logic [CNT_W-1:0]    post_cnt;
  logic [CNT_W-1:0]    cnt;

  // The pending word leaves this cycle, so any new field starts an empty accumulator.
  assign fresh = (state_q == FLUSH_PEND);

  bit_packer_acc u_acc (
    .clock       (clock),
    .reset       (reset),
    .push_i      (pushin),
    .len_i       (lenin),
    .data_i      (datain),
    .fresh_i     (fresh),
    .drop_i      (drop),
    .held_word_o (held_word),
    .word_o      (word),
    .done_o      (done),
    .post_cnt_o  (post_cnt),
    .cnt_o       (cnt)
  );

  always_comb begin
    state_d   = RUN;
    pushout_d = 1'b0;
    dataout_d = dataout_q;
    drop      = 1'b0;
    if (state_q == FLUSH_PEND) begin
      pushout_d = 1'b1;
      dataout_d = held_word;
      if (flushin && (post_cnt != '0)) state_d = FLUSH_PEND;
    end else if (done) begin
      pushout_d = 1'b1;
      dataout_d = word;
      // Output port is busy with the completed word; the residual goes out next cycle.
      if (flushin && (post_cnt != '0)) state_d = FLUSH_PEND;
    end else if (flushin && (post_cnt != '0)) begin
      pushout_d = 1'b1;
      dataout_d = word;
      drop      = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      pushout_q <= 1'b0;
      dataout_q <= '0;
    end else begin
      state_q   <= state_d;
      pushout_q <= pushout_d;
      dataout_q <= dataout_d;
    end
  end

  assign pushout = pushout_q;
  assign dataout = dataout_q;
  assign fillout = cnt;

endmodule

// File: tb/tb_bit_packer.sv
// Directed bench for bit_packer: expected words queue up as stimulus is driven
// and are matched against each pushout strobe; fillout is checked every cycle.
module tb_bit_packer;
  import bit_packer_pkg::*;

  logic               clock;
  logic               reset;
  logic               pushin;
  logic [LEN_W-1:0]   lenin;
  logic [FIELD_W-1:0] datain;
  logic               flushin;
  logic               pushout;
  logic [WORD_W-1:0]  dataout;
  logic [CNT_W-1:0]   fillout;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  bit_packer dut (
    .clock   (clock),
    .reset   (reset),
    .pushin  (pushin),
    .lenin   (lenin),
    .datain  (datain),
    .flushin (flushin),
    .pushout (pushout),
    .dataout (dataout),
    .fillout (fillout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] w);
    sb.push_back(w);
  endtask

  // One clock of stimulus, then check strobe, word (if due) and fill after the edge.
  task automatic step(input string tag, input logic p, input int len, input logic [14:0] d,
                      input logic f, input int fill);
    logic [31:0] exp_w;
    pushin  = p;
    lenin   = LEN_W'(len);
    datain  = d;
    flushin = f;
    @(posedge clock);
    #1;
    check({tag, ".pushout"}, {31'b0, pushout}, {31'b0, (sb.size() != 0)});
    if (sb.size() != 0) begin
      exp_w = sb.pop_front();
      if (pushout === 1'b1) check({tag, ".dataout"}, dataout, exp_w);
    end
    check({tag, ".fillout"}, 32'(fillout), 32'(fill));
  endtask

  initial begin
    reset   = 1'b1;
    pushin  = 1'b0;
    lenin   = '0;
    datain  = '0;
    flushin = 1'b0;

    step("rst0", 0, 0, 0, 0, 0);
    step("rst1", 0, 0, 0, 0, 0);
    check("rst.dataout", dataout, 32'h0);
    reset = 1'b0;

    // Eight nibbles 1..8 make exactly one word.
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) expect_word(32'h12345678);
      step("nib8", 1, 4, 15'(i), 0, (i * 4) % 32);
    end

    // Reset mid-stream at fill 20 discards the residual; reset beats a push.
    for (int i = 9; i <= 13; i++) step("pre_rst", 1, 4, 15'(i), 0, (i - 8) * 4);
    reset = 1'b1;
    step("mid_rst0", 1, 4, 15'hF, 0, 0);
    step("mid_rst1", 1, 4, 15'hF, 0, 0);
    check("mid_rst.dataout", dataout, 32'h0);
    reset = 1'b0;
    step("post_rst_flush", 0, 0, 0, 1, 0);
    step("post_rst_idle", 0, 0, 0, 0, 0);

    // Long fields crossing a word boundary, then flush the 2-bit residual.
    step("wide0", 1, 15, 15'h7FFF, 0, 15);
    step("wide1", 1, 15, 15'h0000, 0, 30);
    expect_word(32'hFFFE0003);
    step("wide2", 1, 4, 15'h000F, 0, 2);
    expect_word(32'hC0000000);
    step("wide_flush", 0, 0, 0, 1, 0);

    // Flush on a word-completing push: two consecutive words.
    for (int i = 1; i <= 7; i++) step("strad_fill", 1, 4, 15'(i), 0, i * 4);
    expect_word(32'h1234567A);
    expect_word(32'hBC000000);
    step("strad", 1, 12, 15'h0ABC, 1, 8);
    step("strad_pend", 0, 0, 0, 0, 0);
    step("strad_idle", 0, 0, 0, 0, 0);

    // Push+flush during FLUSH_PEND re-enters it: three pulses back to back.
    for (int i = 1; i <= 7; i++) step("reent_fill", 1, 4, 15'(i), 0, i * 4);
    expect_word(32'h1234567A);
    expect_word(32'hBC000000);
    expect_word(32'hF8000000);
    step("reent", 1, 12, 15'h0ABC, 1, 8);
    step("reent_pend", 1, 5, 15'h001F, 1, 5);
    step("reent_pend2", 0, 0, 0, 0, 0);
    step("reent_idle", 0, 0, 0, 0, 0);

    // Push without flush during FLUSH_PEND seeds a fresh accumulator.
    for (int i = 1; i <= 7; i++) step("fresh_fill", 1, 4, 15'(i), 0, i * 4);
    expect_word(32'h1234567A);
    expect_word(32'hBC000000);
    step("fresh", 1, 12, 15'h0ABC, 1, 8);
    step("fresh_pend", 1, 4, 15'h0009, 0, 4);
    expect_word(32'h90000000);
    step("fresh_flush", 0, 0, 0, 1, 0);

    // Masking of bits above lenin, and the two no-op forms.
    step("mask", 1, 3, 15'h7FFF, 0, 3);
    step("len0", 1, 0, 15'h1234, 0, 3);
    step("nopush", 0, 9, 15'h01FF, 0, 3);
    expect_word(32'hE0000000);
    step("mask_flush", 0, 0, 0, 1, 0);

    // Largest fill (31) followed by the largest field.
    step("max0", 1, 15, 15'h7FFF, 0, 15);
    step("max1", 1, 15, 15'h7FFF, 0, 30);
    step("max2", 1, 1, 15'h0001, 0, 31);
    expect_word(32'hFFFFFFFE);
    step("max3", 1, 15, 15'h0001, 0, 14);
    expect_word(32'h00040000);
    step("max_flush", 0, 0, 0, 1, 0);

    // Flush on an exactly completed word leaves nothing pending.
    for (int i = 1; i <= 7; i++) step("exact_fill", 1, 4, 15'(i), 0, i * 4);
    expect_word(32'h12345679);
    step("exact", 1, 4, 15'h0009, 1, 0);
    step("exact_idle", 0, 0, 0, 1, 0);
    step("exact_idle2", 0, 0, 0, 0, 0);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
